instr_mem_bank: RTL and testbench

INSTR_MEM_BANK -- requirements
Module: instr_mem_bank

---
 rtl/instr_mem_bank_if.sv | 28 ++
 rtl/instr_mem_bank.sv | 137 +++++++++++++
 tb/tb_instr_mem_bank.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_bank_if.sv
// Bus bundle for instr_mem_bank: read port, byte-enabled write port, clear control and error flag.
// The master drives requests and control; the slave (the memory) drives grants, data and status.
interface instr_mem_bank_if;
    logic        rd_req;
    logic        rd_gnt;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        wr_req;
    logic        wr_gnt;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        clr_start;
    logic        clr_busy;
    logic        clr_done;
    logic        err_clr;
    logic        err_oob;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be, clr_start, err_clr,
        input  rd_gnt, rd_data, wr_gnt, clr_busy, clr_done, err_oob
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be, clr_start, err_clr,
        output rd_gnt, rd_data, wr_gnt, clr_busy, clr_done, err_oob
    );
endinterface

// File: rtl/instr_mem_bank.sv
// Word-addressed 32-bit instruction memory with byte-enabled writes, 1- or 2-cycle read latency,
// a background full-memory clear engine and a sticky out-of-range access flag.
module instr_mem_bank #(
    parameter int ADDR_W   = 10,
    parameter int RD_LAT   = 1,
    parameter bit WRITABLE = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    instr_mem_bank_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       rd_s1_q, rd_s1_d;

    logic [31:0]       mem_q [DEPTH];

    logic              busy;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic              rd_oob;
    logic              wr_oob;
    logic              wr_take;
    logic              err_set;
    logic              unused_addr_bits;

    assign busy   = (state_q == CLEAR);
    assign rd_idx = bus.rd_addr[ADDR_W+1:2];
    assign wr_idx = bus.wr_addr[ADDR_W+1:2];
    assign rd_oob = |bus.rd_addr[31:ADDR_W+2];
    assign wr_oob = |bus.wr_addr[31:ADDR_W+2];

    // Sub-word byte offsets carry no meaning for a word memory.
    assign unused_addr_bits = ^{bus.rd_addr[1:0], bus.wr_addr[1:0]};

    assign bus.rd_gnt   = bus.rd_req & ~busy;
    assign bus.wr_gnt   = bus.wr_req & ~busy;
    assign bus.clr_busy = busy;
    assign bus.clr_done = done_q;
    assign bus.err_oob  = err_q;

    // Illegal writes are still granted so the master never stalls on them; they are only flagged.
    assign wr_take = bus.wr_gnt & ~wr_oob & WRITABLE;
    assign err_set = (bus.rd_gnt & rd_oob) | (bus.wr_gnt & (wr_oob | ~WRITABLE));

    always_comb begin
        err_d = err_q;
        if (err_set) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end
    end

    always_comb begin
        rd_s1_d = '0;
        if (bus.rd_gnt && !rd_oob) begin
            rd_s1_d = mem_q[rd_idx];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == '1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rd_s1_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_s1_q <= rd_s1_d;
        end
    end

    // Memory contents survive reset; the clear engine owns the write port while busy.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_take) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.wr_be[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= bus.wr_data[8*b +: 8];
                end
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [31:0] rd_s2_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_s2_q <= '0;
            end else begin
                rd_s2_q <= rd_s1_q;
            end
        end
        assign bus.rd_data = rd_s2_q;
    end else begin : g_lat1
        assign bus.rd_data = rd_s1_q;
    end
endmodule

// File: tb/tb_instr_mem_bank.sv
// Directed bench for instr_mem_bank: three instances (1-cycle RAM, 2-cycle RAM, ROM) checked
// through a scoreboard of time-stamped expectations popped by an independent monitor.
module tb_instr_mem_bank;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_mem_bank_if b1();
    instr_mem_bank_if b2();
    instr_mem_bank_if b3();

    instr_mem_bank #(.ADDR_W(4), .RD_LAT(1), .WRITABLE(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    instr_mem_bank #(.ADDR_W(4), .RD_LAT(2), .WRITABLE(1'b1)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
    instr_mem_bank #(.ADDR_W(4), .RD_LAT(1), .WRITABLE(1'b0)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

    // kind: 0 rd_data, 1 err_oob, 2 clr_busy, 3 clr_done
    typedef struct {
        int          due;
        int          kind;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    function automatic void chk(string tag, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %08h want %08h (cycle %0d)", tag, act, want, cyc);
        end else begin
            $display("ok   %s: got %08h (cycle %0d)", tag, act, cyc);
        end
    endfunction

    function automatic logic [31:0] pick(int d, int kind);
        logic [31:0] rd;
        logic        eo, cb, cd;
        if (d == 1) begin
            rd = b1.rd_data; eo = b1.err_oob; cb = b1.clr_busy; cd = b1.clr_done;
        end else if (d == 2) begin
            rd = b2.rd_data; eo = b2.err_oob; cb = b2.clr_busy; cd = b2.clr_done;
        end else begin
            rd = b3.rd_data; eo = b3.err_oob; cb = b3.clr_busy; cd = b3.clr_done;
        end
        case (kind)
            0:       return rd;
            1:       return {31'b0, eo};
            2:       return {31'b0, cb};
            default: return {31'b0, cd};
        endcase
    endfunction

    task automatic push(int d, int lat, int kind, logic [31:0] v, string tag);
        exp_t e;
        int   i;
        e.due  = cyc + lat;
        e.kind = kind;
        e.val  = v;
        e.tag  = tag;
        if (d == 1) begin
            i = q1.size();
            while (i > 0 && q1[i-1].due > e.due) i--;
            q1.insert(i, e);
        end else if (d == 2) begin
            i = q2.size();
            while (i > 0 && q2[i-1].due > e.due) i--;
            q2.insert(i, e);
        end else begin
            i = q3.size();
            while (i > 0 && q3[i-1].due > e.due) i--;
            q3.insert(i, e);
        end
    endtask

    // Monitor: one sample per cycle, just after the active edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (q1.size() > 0 && q1[0].due <= cyc) begin
                e = q1.pop_front();
                chk(e.tag, pick(1, e.kind), e.val);
            end
            while (q2.size() > 0 && q2[0].due <= cyc) begin
                e = q2.pop_front();
                chk(e.tag, pick(2, e.kind), e.val);
            end
            while (q3.size() > 0 && q3[0].due <= cyc) begin
                e = q3.pop_front();
                chk(e.tag, pick(3, e.kind), e.val);
            end
        end
    end

    task automatic set(int d, bit rr, logic [31:0] ra, bit wr, logic [31:0] wa,
                       logic [31:0] wd, logic [3:0] be, bit ec, bit cs);
        case (d)
            1: begin
                b1.rd_req = rr; b1.rd_addr = ra; b1.wr_req = wr; b1.wr_addr = wa;
                b1.wr_data = wd; b1.wr_be = be; b1.err_clr = ec; b1.clr_start = cs;
            end
            2: begin
                b2.rd_req = rr; b2.rd_addr = ra; b2.wr_req = wr; b2.wr_addr = wa;
                b2.wr_data = wd; b2.wr_be = be; b2.err_clr = ec; b2.clr_start = cs;
            end
            default: begin
                b3.rd_req = rr; b3.rd_addr = ra; b3.wr_req = wr; b3.wr_addr = wa;
                b3.wr_data = wd; b3.wr_be = be; b3.err_clr = ec; b3.clr_start = cs;
            end
        endcase
    endtask

    task automatic drv(int d, bit rr, logic [31:0] ra, bit wr, logic [31:0] wa,
                       logic [31:0] wd, logic [3:0] be, bit ec, bit cs);
        @(negedge clk);
        set(d, rr, ra, wr, wa, wd, be, ec, cs);
    endtask

    task automatic idle(int d);
        drv(d, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic wr(int d, logic [31:0] a, logic [31:0] v, logic [3:0] be);
        drv(d, 1'b0, 32'h0, 1'b1, a, v, be, 1'b0, 1'b0);
    endtask

    task automatic rd(int d, logic [31:0] a, int lat, logic [31:0] want, string tag);
        drv(d, 1'b1, a, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        push(d, lat, 0, want, tag);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 1; d <= 3; d++) set(d, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_rd_data", b1.rd_data, 32'h0);
        chk("rst_rd_data2", b2.rd_data, 32'h0);
        chk("rst_err", {31'b0, b1.err_oob}, 32'h0);
        chk("rst_busy", {31'b0, b1.clr_busy}, 32'h0);
        chk("rst_done", {31'b0, b1.clr_done}, 32'h0);
        rst = 1'b0;

        // Basic write/read and idle-cycle zeroing.
        wr(1, 32'h8, 32'hDEADBEEF, 4'hF);
        push(1, 1, 0, 32'h0, "wr_cycle_rd_zero");
        rd(1, 32'h8, 1, 32'hDEADBEEF, "rd_word2");
        idle(1);
        push(1, 1, 0, 32'h0, "idle_rd_zero");

        // Byte enables and read-first on collision.
        wr(1, 32'hC, 32'h11223344, 4'hF);
        drv(1, 1'b1, 32'hC, 1'b1, 32'hC, 32'h0000AA00, 4'h2, 1'b0, 1'b0);
        push(1, 1, 0, 32'h11223344, "read_first");
        rd(1, 32'hC, 1, 32'h1122AA44, "be2_merge");
        wr(1, 32'hC, 32'hFFFFFFFF, 4'h0);
        rd(1, 32'hE, 1, 32'h1122AA44, "be0_keep_lowbits");
        wr(1, 32'h8, 32'h55667788, 4'h9);
        rd(1, 32'h8, 1, 32'h55ADBE88, "be9_merge");
        push(1, 1, 1, 32'h0, "err_quiet");
        wr(1, 32'h3C, 32'hCAFEF00D, 4'hF);
        rd(1, 32'h3C, 1, 32'hCAFEF00D, "top_word");
        push(1, 1, 1, 32'h0, "top_in_range");
        wr(1, 32'h0, 32'h01010101, 4'hF);

        // Out-of-range accesses and the sticky flag.
        rd(1, 32'h40, 1, 32'h0, "oob_rd_zero");
        push(1, 1, 1, 32'h1, "oob_sets_err");
        drv(1, 1'b0, 32'h0, 1'b1, 32'h80, 32'h77777777, 4'hF, 1'b1, 1'b0);
        #1 chk("oob_wr_gnt", {31'b0, b1.wr_gnt}, 32'h1);
        push(1, 1, 1, 32'h1, "set_beats_clr");
        drv(1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        push(1, 1, 1, 32'h0, "err_clr");
        rd(1, 32'h0, 1, 32'h01010101, "oob_wr_dropped");

        // Full clear: busy for 16 cycles, no grants, single done pulse.
        for (int w = 0; w < 16; w++) wr(1, 32'(w * 4), 32'hA0000000 | 32'(w), 4'hF);
        drv(1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 18; i++) begin
            push(1, i, 2, (i <= 16) ? 32'h1 : 32'h0, "clr_busy");
            push(1, i, 3, (i == 17) ? 32'h1 : 32'h0, "clr_done");
        end
        for (int i = 1; i <= 16; i++) begin
            drv(1, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, (i == 3));
            #1 chk("clr_no_gnt", {31'b0, b1.rd_gnt}, 32'h0);
            push(1, 1, 0, 32'h0, "clr_rd_zero");
        end
        idle(1);
        for (int w = 0; w < 16; w++) rd(1, 32'(w * 4), 1, 32'h0, "cleared_word");

        // Clear aborted by reset partway through.
        for (int w = 0; w < 16; w++) wr(1, 32'(w * 4), 32'hB0000000 | 32'(w), 4'hF);
        drv(1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 20; i++) push(1, i, 3, 32'h0, "abort_no_done");
        for (int i = 1; i <= 5; i++) push(1, i, 2, 32'h1, "abort_busy_pre");
        for (int i = 1; i <= 6; i++) idle(1);
        rst = 1'b1;
        #1 chk("abort_busy_low", {31'b0, b1.clr_busy}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(1, 32'h0, 1, 32'h0, "abort_word0_cleared");
        for (int w = 5; w < 16; w++) rd(1, 32'(w * 4), 1, 32'hB0000000 | 32'(w), "abort_word_kept");
        idle(1);

        // Two-cycle latency streaming.
        wr(2, 32'h0, 32'h00000100, 4'hF);
        wr(2, 32'h4, 32'h00000200, 4'hF);
        wr(2, 32'h8, 32'h00000300, 4'hF);
        rd(2, 32'h0, 2, 32'h00000100, "lat2_s0");
        push(2, 1, 0, 32'h0, "lat2_not_early");
        rd(2, 32'h4, 2, 32'h00000200, "lat2_s1");
        rd(2, 32'h8, 2, 32'h00000300, "lat2_s2");
        idle(2);
        push(2, 2, 0, 32'h0, "lat2_tail_zero");

        // ROM: clear it to a known state, then a write is granted, dropped and flagged.
        drv(3, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        push(3, 17, 3, 32'h1, "rom_clr_done");
        for (int i = 1; i <= 18; i++) idle(3);
        rd(3, 32'h0, 1, 32'h0, "rom_pre");
        push(3, 1, 1, 32'h0, "rom_err_quiet");
        wr(3, 32'h0, 32'h12345678, 4'hF);
        #1 chk("rom_wr_gnt", {31'b0, b3.wr_gnt}, 32'h1);
        push(3, 1, 1, 32'h1, "rom_err_set");
        rd(3, 32'h0, 1, 32'h0, "rom_unchanged");
        idle(3);

        repeat (4) @(negedge clk);
        if (q1.size() + q2.size() + q3.size() != 0) begin
            total++;
            bad++;
            $display("FAIL queue_leftover: got %0d want 0", q1.size() + q2.size() + q3.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
